upd7800_clkgen: RTL and testbench

- Timing front end for the uPD7800 core; sits directly upstream of the CPU.
- Divides the system clock into the CPU's two-phase, non-overlapping state clock.
- Delivers the phase clock as single-cycle edge-enable pulses (CP1_POSEDGE/NEGEDGE, CP2_POSEDGE/NEGEDGE) plus level copies.
- Also provides WAIT-state stretching, a CE pause input, external-reset synchronisation and the CPU's RESETB with a minimum hold time.

---
 rtl/upd7800_clkgen.sv | 72 +++++++
 tb/tb_upd7800_clkgen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/upd7800_clkgen.sv
// upd7800_clkgen: two-phase CPU state clock generator with WAIT stretch, CE pause and RESETB sequencing
module upd7800_clkgen #(
  parameter int DIV        = 4,
  parameter int RES_STATES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        WAIT,
  input  logic        EXT_RESB,
  output logic        CP1_POSEDGE,
  output logic        CP1_NEGEDGE,
  output logic        CP2_POSEDGE,
  output logic        CP2_NEGEDGE,
  output logic        CP1,
  output logic        CP2,
  output logic        RESETB,
  output logic [15:0] STATE_CNT
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] P_Q    = PW'(DIV / 4);
  localparam logic [PW-1:0] P_2Q   = PW'(DIV / 2);
  localparam logic [PW-1:0] P_3Q   = PW'(3 * DIV / 4);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [7:0]    P_RES  = 8'(RES_STATES);
  logic [PW-1:0] r_ph;
  logic [7:0]    r_rcnt;
  logic [1:0]    r_sync;
  logic [15:0]   r_state_cnt;
  logic          r_p1p, r_p1n, r_p2p, r_p2n, r_cp1, r_cp2, r_resetb;
  logic          w_p1p, w_p1n, w_p2p, w_p2n, w_hold;
  assign w_p1p  = CE && r_ph == '0;
  assign w_p1n  = CE && r_ph == P_Q;
  assign w_p2p  = CE && r_ph == P_2Q;
  assign w_hold = CE && r_ph == P_3Q && WAIT;
  assign w_p2n  = CE && r_ph == P_3Q && !WAIT;
  // Reload on a CE edge with the synced request low wins over any pending RESETB rise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ph        <= '0;
      {r_p1p, r_p1n, r_p2p, r_p2n} <= '0;
      r_cp1       <= 1'b0;
      r_cp2       <= 1'b0;
      r_resetb    <= 1'b0;
      r_rcnt      <= P_RES;
      r_state_cnt <= '0;
      r_sync      <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], EXT_RESB};
      {r_p1p, r_p1n, r_p2p, r_p2n} <= {w_p1p, w_p1n, w_p2p, w_p2n};
      if (CE && !w_hold) r_ph <= r_ph == P_LAST ? '0 : r_ph + 1'b1;
      r_cp1       <= w_p1p | (r_cp1 & ~w_p1n);
      r_cp2       <= w_p2p | (r_cp2 & ~w_p2n);
      r_state_cnt <= r_state_cnt + 16'(w_p2n);
      if (CE && !r_sync[1]) begin
        r_rcnt   <= P_RES;
        r_resetb <= 1'b0;
      end else begin
        if (w_p2n && r_rcnt != 8'd0) r_rcnt <= r_rcnt - 8'd1;
        if (w_p1p && r_rcnt == 8'd0) r_resetb <= 1'b1;
      end
    end
  end
  assign CP1_POSEDGE = r_p1p;
  assign CP1_NEGEDGE = r_p1n;
  assign CP2_POSEDGE = r_p2p;
  assign CP2_NEGEDGE = r_p2n;
  assign CP1         = r_cp1;
  assign CP2         = r_cp2;
  assign RESETB      = r_resetb;
  assign STATE_CNT   = r_state_cnt;
endmodule

// File: tb/tb_upd7800_clkgen.sv
// tb_upd7800_clkgen: vector table plus per-cycle scoreboard against a behavioural phase model
module tb_upd7800_clkgen;
  logic CLK = 1'b0, RESET = 1'b1, CE = 1'b0, WAIT = 1'b0, EXT_RESB = 1'b1;
  logic p1p4, p1n4, p2p4, p2n4, cp14, cp24, rb4;
  logic p1p8, p1n8, p2p8, p2n8, cp18, cp28, rb8;
  logic [15:0] sc4, sc8;
  typedef struct {
    int ph; logic cp1, cp2, rb, s0, s1; logic [3:0] p; int rcnt; logic [15:0] sc;
  } mdl_t;
  typedef struct {logic ce, wt; logic [3:0] p; logic cp1, cp2;} vec_t;
  mdl_t m4, m8;
  logic [22:0] q4[$], q8[$];
  vec_t tbl[13];
  int n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  upd7800_clkgen #(.DIV(4), .RES_STATES(16)) u4 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WAIT(WAIT), .EXT_RESB(EXT_RESB),
    .CP1_POSEDGE(p1p4), .CP1_NEGEDGE(p1n4), .CP2_POSEDGE(p2p4), .CP2_NEGEDGE(p2n4),
    .CP1(cp14), .CP2(cp24), .RESETB(rb4), .STATE_CNT(sc4));
  upd7800_clkgen #(.DIV(8), .RES_STATES(3)) u8 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WAIT(WAIT), .EXT_RESB(EXT_RESB),
    .CP1_POSEDGE(p1p8), .CP1_NEGEDGE(p1n8), .CP2_POSEDGE(p2p8), .CP2_NEGEDGE(p2n8),
    .CP1(cp18), .CP2(cp28), .RESETB(rb8), .STATE_CNT(sc8));
  // p[0..3] = CP1 rise, CP1 fall, CP2 rise, CP2 fall; event k fires at ph == k*Q
  function automatic mdl_t step(input mdl_t m, input int div, input int res);
    mdl_t n;
    int q;
    logic held;
    n = m;
    q = div / 4;
    if (RESET) begin
      n.ph = 0; n.p = '0; n.cp1 = 0; n.cp2 = 0; n.rb = 0;
      n.rcnt = res; n.sc = '0; n.s0 = 1; n.s1 = 1;
      return n;
    end
    n.s0 = EXT_RESB;
    n.s1 = m.s0;
    n.p = '0;
    if (!CE) return n;
    held = (m.ph == 3 * q) && WAIT;
    if (m.ph % q == 0 && !held) n.p[m.ph / q] = 1'b1;
    if (!held) n.ph = (m.ph + 1) % div;
    if (n.p[0]) n.cp1 = 1'b1;
    if (n.p[1]) n.cp1 = 1'b0;
    if (n.p[2]) n.cp2 = 1'b1;
    if (n.p[3]) n.cp2 = 1'b0;
    if (n.p[3]) n.sc = m.sc + 16'd1;
    if (!m.s1) begin
      n.rcnt = res;
      n.rb = 1'b0;
    end else begin
      if (n.p[3] && m.rcnt > 0) n.rcnt = m.rcnt - 1;
      if (n.p[0] && m.rcnt == 0) n.rb = 1'b1;
    end
    return n;
  endfunction
  function automatic logic [22:0] pk(input mdl_t m);
    return {m.p, m.cp1, m.cp2, m.rb, m.sc};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic c, input logic w, input logic e);
    RESET = r; CE = c; WAIT = w; EXT_RESB = e;
    m4 = step(m4, 4, 16);
    m8 = step(m8, 8, 3);
    q4.push_back(pk(m4));
    q8.push_back(pk(m8));
    @(posedge CLK);
    #1;
    chk("sb_div4", {9'd0, p2n4, p2p4, p1n4, p1p4, cp14, cp24, rb4, sc4}, {9'd0, q4.pop_front()});
    chk("sb_div8", {9'd0, p2n8, p2p8, p1n8, p1p8, cp18, cp28, rb8, sc8}, {9'd0, q8.pop_front()});
  endtask
  task automatic do_reset();
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
  endtask
  task automatic set_sc4();
    force u4.r_state_cnt = 16'hFFFF;
    #1;
    release u4.r_state_cnt;
    m4.sc = 16'hFFFF;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int rise, cnt, hi;
    tbl[0]  = '{1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'b0100, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 4'b1000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 4'b1000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    do_reset();
    chk("reset_state", {p2n4, p2p4, p1n4, p1p4, cp14, cp24, rb4, sc4}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      cyc(1'b0, tbl[i].ce, tbl[i].wt, 1'b1);
      chk($sformatf("vec%0d", i), {p2n4, p2p4, p1n4, p1p4, cp14, cp24},
          {26'd0, tbl[i].p, tbl[i].cp1, tbl[i].cp2});
    end
    // RESETB rises with the 17th CP1 rise after release (cycle 65)
    do_reset();
    rise = -1;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      if (i + 1 == 64) chk("sc_at_64", {16'd0, sc4}, 32'd16);
      if (rb4 === 1'b1) rise = i + 1;
    end
    chk("resetb_rise_cycle", rise, 32'd65);
    // CE alternating halves the rate: rise at cycle 129
    do_reset();
    rise = -1;
    for (int i = 0; i < 400 && rise < 0; i++) begin
      cyc(1'b0, i % 2 == 0, 1'b0, 1'b1);
      if (i % 2 == 1 && i < 12) chk("ce0_no_pulse", {p2n4, p2p4, p1n4, p1p4}, 32'd0);
      if (rb4 === 1'b1) rise = i + 1;
    end
    chk("ce_alt_rise_cycle", rise, 32'd129);
    // One-cycle EXT_RESB low, aligned so the first edge is at ph==1
    for (int i = 0; i < 8 && p1p4 !== 1'b1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ext_align", {31'd0, p1p4}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ext_rb_edge2", {31'd0, rb4}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ext_rb_edge3", {31'd0, rb4}, 32'd0);
    rise = -1;
    cnt = 0;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      if (p1p4 === 1'b1) cnt++;
      if (rb4 === 1'b1) rise = i;
    end
    chk("ext_rise_found", {31'd0, rise >= 0}, 32'd1);
    chk("ext_rise_p1p_count", cnt, 32'd17);
    // DIV=8 WAIT stretch: CP2 high 5 cycles, CP2 fall delayed 3, CP1 rise 2 later
    do_reset();
    for (int i = 0; i < 20 && p2p8 !== 1'b1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("div8_find_p2p", {31'd0, p2p8}, 32'd1);
    hi = 1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    if (cp28 === 1'b1) hi++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("div8_wait_hold", {30'd0, p2n8, cp28}, 32'd1);
      if (cp28 === 1'b1) hi++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("div8_wait_release", {30'd0, p2n8, cp28}, 32'd2);
    chk("div8_cp2_high", hi, 32'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("div8_next_p1p", {31'd0, p1p8}, 32'd1);
    // RESET during a WAIT hold with STATE_CNT at FFFF
    do_reset();
    for (int i = 0; i < 8 && p2p4 !== 1'b1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("div4_find_p2p", {31'd0, p2p4}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    set_sc4();
    chk("sc_forced", {16'd0, sc4}, 32'h0000FFFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_in_wait", {p2n4, p2p4, p1n4, p1p4, cp14, cp24, rb4, sc4}, 32'd0);
    // STATE_CNT wrap without reset
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8 && p2p4 !== 1'b1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    set_sc4();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("sc_wrap", {15'd0, p2n4, sc4}, 32'h00010000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
